// File: rtl/data_memory_ctrl.sv
// Single-port data memory with request/response handshake, byte-lane writes,
// alignment/range checking and a post-reset init sweep.
module data_memory_ctrl #(
  parameter int DATA_W    = 32,
  parameter int DEPTH     = 32,
  parameter int ADDR_W    = 32,
  parameter int INIT_MODE = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req,
  input  logic                we,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [DATA_W-1:0]   wd,
  input  logic [DATA_W/8-1:0] be,
  output logic                ready,
  output logic                resp_valid,
  output logic                resp_err,
  output logic [DATA_W-1:0]   rdata,
  output logic                init_done
);

  localparam int NBYTES = DATA_W / 8;
  localparam int OFFS   = $clog2(NBYTES);
  localparam int IDX_W  = $clog2(DEPTH);

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t             state_r;
  state_t             state_nxt_s;
  logic [IDX_W-1:0]   init_cnt_r;
  logic [DATA_W-1:0]  mem_r [DEPTH];
  logic               ready_r;
  logic               init_done_r;
  logic               resp_valid_r;
  logic               resp_err_r;
  logic [DATA_W-1:0]  rdata_r;

  logic               init_we_s;
  logic [DATA_W-1:0]  init_word_s;
  logic               accept_s;
  logic               misalign_s;
  logic               oor_s;
  logic               err_s;
  logic               wr_en_s;
  logic               rd_en_s;
  logic [IDX_W-1:0]   idx_s;
  logic [ADDR_W-1:0]  addr_hi_s;

  // Next-state logic of the init sweep
  always_comb begin
    state_nxt_s = state_r;
    init_we_s   = 1'b0;
    case (state_r)
      ST_INIT: begin
        init_we_s = 1'b1;
        if (init_cnt_r == IDX_W'(DEPTH - 1)) begin
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_INIT;
        end
      end
      ST_RUN:  state_nxt_s = ST_RUN;
      default: state_nxt_s = ST_INIT;
    endcase
  end

  // Init pattern for the word currently addressed by the sweep counter
  always_comb begin
    init_word_s = '0;
    if (INIT_MODE == 1) begin
      init_word_s = DATA_W'(init_cnt_r);
    end else begin
      init_word_s = '0;
    end
  end

  // Request decode: any address bit above the word index means out of range
  always_comb begin
    accept_s   = req & ready_r;
    misalign_s = |addr[OFFS-1:0];
    addr_hi_s  = addr >> (OFFS + IDX_W);
    oor_s      = |addr_hi_s;
    err_s      = misalign_s | oor_s;
    idx_s      = addr[OFFS +: IDX_W];
    wr_en_s    = accept_s & we & ~err_s;
    rd_en_s    = accept_s & ~we & ~err_s;
  end

  // Control state, sweep counter and registered response outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r      <= ST_INIT;
      init_cnt_r   <= '0;
      ready_r      <= 1'b0;
      init_done_r  <= 1'b0;
      resp_valid_r <= 1'b0;
      resp_err_r   <= 1'b0;
      rdata_r      <= '0;
    end else begin
      state_r      <= state_nxt_s;
      init_cnt_r   <= init_we_s ? init_cnt_r + IDX_W'(1) : init_cnt_r;
      ready_r      <= (state_nxt_s == ST_RUN);
      init_done_r  <= (state_nxt_s == ST_RUN);
      resp_valid_r <= accept_s;
      resp_err_r   <= accept_s & err_s;
      rdata_r      <= rd_en_s ? mem_r[idx_s] : '0;
    end
  end

  // Storage array; contents are defined only once the sweep has run
  always_ff @(posedge clk) begin
    if (init_we_s) begin
      mem_r[init_cnt_r] <= init_word_s;
    end else if (wr_en_s) begin
      for (int k = 0; k < NBYTES; k++) begin
        if (be[k]) begin
          mem_r[idx_s][8*k +: 8] <= wd[8*k +: 8];
        end
      end
    end
  end

  assign ready      = ready_r;
  assign init_done  = init_done_r;
  assign resp_valid = resp_valid_r;
  assign resp_err   = resp_err_r;
  assign rdata      = rdata_r;

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Scoreboard bench for data_memory_ctrl: stimulus pushes expected responses
// from a word-array model; a negedge monitor pops and compares them.
module tb_data_memory_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wd;
  logic [3:0]  be;
  logic        ready;
  logic        resp_valid;
  logic        resp_err;
  logic [31:0] rdata;
  logic        init_done;

  data_memory_ctrl #(
    .DATA_W(32), .DEPTH(32), .ADDR_W(32), .INIT_MODE(1)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wd(wd), .be(be),
    .ready(ready), .resp_valid(resp_valid), .resp_err(resp_err),
    .rdata(rdata), .init_done(init_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned due;
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] ref_mem [32];
  int unsigned cyc = 0;
  int          checks = 0;
  int          errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void model_init();
    for (int i = 0; i < 32; i++) ref_mem[i] = 32'(i);
  endfunction

  // Reference behaviour: byte address -> word, reject misaligned/out of range
  function automatic void model(input logic w, input logic [31:0] a,
                                input logic [31:0] d, input logic [3:0] b,
                                output logic err, output logic [31:0] rd);
    int unsigned idx;
    idx = a / 4;
    err = (a % 4 != 0) || (idx >= 32);
    rd  = 32'h0;
    if (!err) begin
      if (w) begin
        for (int k = 0; k < 4; k++)
          if (b[k]) ref_mem[idx][8*k +: 8] = d[8*k +: 8];
      end else begin
        rd = ref_mem[idx];
      end
    end
  endfunction

  task automatic issue(input logic w, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] b);
    exp_t e;
    @(negedge clk);
    req = 1'b1; we = w; addr = a; wd = d; be = b;
    if (ready) begin
      model(w, a, d, b, e.err, e.rdata);
      e.due = cyc + 1;
      sb.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      req = 1'b0;
    end
  endtask

  // Count edges from reset release until ready; random requests must be ignored
  task automatic measure_sweep(input bit rand_req);
    int n = 0;
    bit done = 1'b0;
    while (!done && n < 100) begin
      @(posedge clk);
      n++;
      #1;
      if (ready) done = 1'b1;
      if (rand_req && !done) begin
        req  = 1'($urandom);
        we   = 1'($urandom);
        addr = 32'($urandom_range(0, 31)) * 32'd4;
        wd   = $urandom;
        be   = 4'b1111;
      end
    end
    req = 1'b0;
    checks++;
    if (n != 32 || init_done !== 1'b1) begin
      errors++;
      $display("FAIL sweep_len: got %0d cycles init_done=%b, expected 32 cycles init_done=1", n, init_done);
    end
  endtask

  // Monitor: every response must match the oldest expectation and be on time
  always @(negedge clk) begin
    if (rst) begin
      if (resp_valid) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_resp: got resp err=%b rdata=%h, expected no response", resp_err, rdata);
        end else begin
          exp_t e;
          e = sb.pop_front();
          if (e.due != cyc || resp_err !== e.err || rdata !== e.rdata) begin
            errors++;
            $display("FAIL resp: got cyc=%0d err=%b rdata=%h, expected cyc=%0d err=%b rdata=%h",
                     cyc, resp_err, rdata, e.due, e.err, e.rdata);
          end
        end
      end else if (sb.size() > 0 && sb[0].due <= cyc) begin
        checks++;
        errors++;
        $display("FAIL missing_resp: got no response at cyc=%0d, expected err=%b rdata=%h",
                 cyc, sb[0].err, sb[0].rdata);
        void'(sb.pop_front());
      end
    end
  end

  initial begin
    logic [31:0] a;
    rst = 1'b0; req = 1'b0; we = 1'b0; addr = 32'h0; wd = 32'h0; be = 4'h0;
    model_init();
    repeat (3) @(negedge clk);
    checks++;
    if (ready !== 1'b0 || resp_valid !== 1'b0 || resp_err !== 1'b0 ||
        rdata !== 32'h0 || init_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_vals: got ready=%b rv=%b err=%b rdata=%h done=%b, expected all 0",
               ready, resp_valid, resp_err, rdata, init_done);
    end
    rst = 1'b1;
    measure_sweep(1'b0);

    // Directed scenarios
    issue(1'b0, 32'h0C, 32'h0, 4'h0);
    issue(1'b0, 32'h7C, 32'h0, 4'h0);
    issue(1'b1, 32'h08, 32'hAABBCCDD, 4'b0101);
    issue(1'b0, 32'h08, 32'h0, 4'h0);
    issue(1'b1, 32'h0A, 32'h11223344, 4'b1111);
    issue(1'b0, 32'h08, 32'h0, 4'h0);
    issue(1'b0, 32'h80, 32'h0, 4'h0);
    issue(1'b1, 32'h80, 32'hDEADBEEF, 4'b1111);
    issue(1'b1, 32'h14, 32'hFFFFFFFF, 4'b0000);
    for (int i = 0; i < 32; i++) issue(1'b0, 32'(i * 4), 32'h0, 4'h0);
    issue(1'b1, 32'h10, 32'h00001234, 4'b1111);
    issue(1'b0, 32'h10, 32'h0, 4'h0);
    idle(3);

    // Randomised traffic with occasional bubbles and bad addresses
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 9))
        0: a = 32'($urandom_range(0, 31)) * 32'd4 + 32'($urandom_range(1, 3));
        1: a = $urandom;
        2: a = 32'h80 + 32'($urandom_range(0, 63)) * 32'd4;
        default: a = 32'($urandom_range(0, 7)) * 32'd4;
      endcase
      if ($urandom_range(0, 7) == 0) idle(1);
      issue(1'($urandom), a, $urandom, 4'($urandom));
    end
    idle(3);

    // Reset in the middle of the sweep, with requests offered throughout
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
    @(negedge clk);
    rst = 1'b1;
    model_init();
    repeat (10) begin
      @(posedge clk);
      #1;
      req = 1'b1; we = 1'($urandom); addr = 32'h4; wd = $urandom; be = 4'hF;
    end
    @(negedge clk);
    rst = 1'b0;
    req = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    measure_sweep(1'b1);
    for (int i = 0; i < 32; i += 5) issue(1'b0, 32'(i * 4), 32'h0, 4'h0);
    idle(3);

    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending responses, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
